// File: rtl/rf_pkg.sv
// Shared widths and the write-back entry layout for the register-file
// write-back arbiter and its long-latency result FIFO.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // One pending long-latency result: destination register plus data.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency write-back results until the
// register file write port is free. Head entry is visible combinationally.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the main pipeline always wins, queued
// long-latency results drain when it is idle. Keeps a busy scoreboard of
// registers awaiting long results and requests a stall when the queue head
// has been starved for too long.
//
// Long-result handshake: a result transfers on a rising edge where
// lng_valid && lng_ready; lng_ready depends only on current occupancy
// (count < DEPTH), never on a same-cycle pop, and the producer must hold
// lng_a/lng_wd stable while lng_valid is high and lng_ready is low.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr,
    input  logic [REG_AW-1:0] pipe_a,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic              lng_valid,
    output logic              lng_ready,
    input  logic [REG_AW-1:0] lng_a,
    input  logic [DATA_W-1:0] lng_wd,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_a,
    output logic [REG_AW-1:0] A3,
    output logic [DATA_W-1:0] WD,
    output logic              RFWr,
    output logic [31:0]       busy,
    output logic              stall_req
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = ($clog2(STARVE_MAX) + 1 < 3) ? 3 : $clog2(STARVE_MAX) + 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

    wb_entry_t         fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              fifo_push;
    logic              fifo_pop;

    logic [REG_AW-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              rfwr_q, rfwr_d;
    logic [31:0]       busy_q, busy_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;

    assign lng_ready = (fifo_count < CW'(DEPTH));
    assign fifo_push = lng_valid && !fifo_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry ('{addr: lng_a, data: lng_wd}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Write-port arbitration: pipeline first, else FIFO head; register 0 is never written.
    always_comb begin
        a3_d     = a3_q;
        wd_d     = wd_q;
        rfwr_d   = 1'b0;
        fifo_pop = 1'b0;
        if (pipe_wr) begin
            a3_d   = pipe_a;
            wd_d   = pipe_wd;
            rfwr_d = (pipe_a != '0);
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            a3_d     = fifo_head.addr;
            wd_d     = fifo_head.data;
            rfwr_d   = (fifo_head.addr != '0);
        end
    end

    // Scoreboard: clear on write-back of a long result, then set on issue so a set wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop && (fifo_head.addr != '0)) busy_d[fifo_head.addr] = 1'b0;
        if (iss_valid && (iss_a != '0))         busy_d[iss_a]          = 1'b1;
    end

    // Starvation tracking: count cycles the head waits behind pipeline writes.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != '1) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = !fifo_empty && pipe_wr && (starve_q >= STARVE_LIM);
    end

    // All architectural state; reset clears outputs, scoreboard and starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a3_q     <= '0;
            wd_q     <= '0;
            rfwr_q   <= 1'b0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            rfwr_q   <= rfwr_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign A3        = a3_q;
    assign WD        = wd_q;
    assign RFWr      = rfwr_q;
    assign busy      = busy_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wr;
    logic [4:0]  pipe_a;
    logic [31:0] pipe_wd;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_a;
    logic [31:0] lng_wd;
    logic        iss_valid;
    logic [4:0]  iss_a;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        RFWr;
    logic [31:0] busy;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_wr   (pipe_wr),
        .pipe_a    (pipe_a),
        .pipe_wd   (pipe_wd),
        .lng_valid (lng_valid),
        .lng_ready (lng_ready),
        .lng_a     (lng_a),
        .lng_wd    (lng_wd),
        .iss_valid (iss_valid),
        .iss_a     (iss_a),
        .A3        (A3),
        .WD        (WD),
        .RFWr      (RFWr),
        .busy      (busy),
        .stall_req (stall_req)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ia;
        logic        e_rfwr;
        logic        chk_aw;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic iv, input logic [4:0] ia,
                                input logic e_rfwr, input logic chk_aw, input logic [4:0] e_a3,
                                input logic [31:0] e_wd, input logic [31:0] e_busy);
        vec_t v;
        v.pw = pw; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.iv = iv; v.ia = ia;
        v.e_rfwr = e_rfwr; v.chk_aw = chk_aw; v.e_a3 = e_a3; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ia);
        pipe_wr = pw; pipe_a = pa; pipe_wd = pd;
        lng_valid = lv; lng_a = la; lng_wd = ld;
        iss_valid = iv; iss_a = ia;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard compare
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // reset state while held
        tick();
        chk("rst_rfwr",  {31'd0, RFWr}, 32'd0);
        chk("rst_a3",    {27'd0, A3}, 32'd0);
        chk("rst_wd",    WD, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_ready", {31'd0, lng_ready}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rel_ready", {31'd0, lng_ready}, 32'd1);
        chk("rel_rfwr",  {31'd0, RFWr}, 32'd0);

        // directed vectors
        tbl[0]  = mk(1, 5'd5,  32'h1234,     0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd5,  32'h1234,     32'h0);
        tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  0, 1, 5'd5,  32'h1234,     32'h0);
        tbl[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    1, 5'd9,  0, 1, 5'd5,  32'h1234,     32'h200);
        tbl[3]  = mk(0, 5'd0,  32'h0,        1, 5'd9, 32'hCAFE, 0, 5'd0,  0, 1, 5'd5,  32'h1234,     32'h200);
        tbl[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd9,  32'hCAFE,     32'h0);
        tbl[5]  = mk(0, 5'd0,  32'h0,        1, 5'd0, 32'hFFFF, 0, 5'd0,  0, 1, 5'd9,  32'hCAFE,     32'h0);
        tbl[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  0, 0, 5'd0,  32'h0,        32'h0);
        tbl[7]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  0, 0, 5'd0,  32'h0,        32'h0);
        tbl[8]  = mk(1, 5'd0,  32'h5555,     0, 5'd0, 32'h0,    0, 5'd0,  0, 0, 5'd0,  32'h0,        32'h0);
        tbl[9]  = mk(1, 5'd31, 32'hDEADBEEF, 1, 5'd3, 32'h33,   1, 5'd4,  1, 1, 5'd31, 32'hDEADBEEF, 32'h10);
        tbl[10] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd3,  32'h33,       32'h10);
        tbl[11] = mk(0, 5'd0,  32'h0,        1, 5'd7, 32'h77,   1, 5'd7,  0, 1, 5'd3,  32'h33,       32'h90);
        tbl[12] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    1, 5'd7,  1, 1, 5'd7,  32'h77,       32'h90);
        tbl[13] = mk(0, 5'd0,  32'h0,        1, 5'd4, 32'h44,   0, 5'd0,  0, 1, 5'd7,  32'h77,       32'h90);
        tbl[14] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd4,  32'h44,       32'h80);
        tbl[15] = mk(0, 5'd0,  32'h0,        1, 5'd1, 32'h11,   0, 5'd0,  0, 1, 5'd4,  32'h44,       32'h80);
        tbl[16] = mk(0, 5'd0,  32'h0,        1, 5'd2, 32'h22,   0, 5'd0,  1, 1, 5'd1,  32'h11,       32'h80);
        tbl[17] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd2,  32'h22,       32'h80);
        tbl[18] = mk(0, 5'd0,  32'h0,        1, 5'd7, 32'h7,    0, 5'd0,  0, 1, 5'd2,  32'h22,       32'h80);
        tbl[19] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  1, 1, 5'd7,  32'h7,        32'h0);
        tbl[20] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  0, 1, 5'd7,  32'h7,        32'h0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].iv, tbl[i].ia);
            tick();
            chk($sformatf("v%0d_rfwr", i), {31'd0, RFWr}, {31'd0, tbl[i].e_rfwr});
            if (tbl[i].chk_aw) begin
                chk($sformatf("v%0d_a3", i), {27'd0, A3}, {27'd0, tbl[i].e_a3});
                chk($sformatf("v%0d_wd", i), WD, tbl[i].e_wd);
            end
            chk($sformatf("v%0d_busy", i),  busy, tbl[i].e_busy);
            chk($sformatf("v%0d_ready", i), {31'd0, lng_ready}, 32'd1);
            chk($sformatf("v%0d_stall", i), {31'd0, stall_req}, 32'd0);
        end

        // fill FIFO under continuous pipeline writes; 5th offer refused; starvation stall
        for (int c = 1; c <= 10; c++) begin
            drive(1'b1, 5'(10 + c), 32'h100 + 32'(c),
                  (c <= 5), 5'(20 + c - 1), 32'hA0 + 32'(c - 1), 1'b0, 5'd0);
            tick();
            chk($sformatf("fill%0d_rfwr", c),  {31'd0, RFWr}, 32'd1);
            chk($sformatf("fill%0d_a3", c),    {27'd0, A3}, 32'(10 + c));
            chk($sformatf("fill%0d_wd", c),    WD, 32'h100 + 32'(c));
            chk($sformatf("fill%0d_ready", c), {31'd0, lng_ready}, (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_stall", c), {31'd0, stall_req}, (c >= 9) ? 32'd1 : 32'd0);
        end
        for (int d = 0; d < 4; d++) begin
            idle();
            tick();
            chk($sformatf("drain%0d_rfwr", d),  {31'd0, RFWr}, 32'd1);
            chk($sformatf("drain%0d_a3", d),    {27'd0, A3}, 32'(20 + d));
            chk($sformatf("drain%0d_wd", d),    WD, 32'hA0 + 32'(d));
            chk($sformatf("drain%0d_stall", d), {31'd0, stall_req}, 32'd0);
            chk($sformatf("drain%0d_ready", d), {31'd0, lng_ready}, 32'd1);
        end
        idle();
        tick();
        chk("drain_end_rfwr", {31'd0, RFWr}, 32'd0);

        // reset with three queued entries and busy bits 9 and 10
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd9,  32'd9,  1'b1, 5'd9);
        tick();
        drive(1'b1, 5'd1, 32'd2, 1'b1, 5'd10, 32'd10, 1'b1, 5'd10);
        tick();
        drive(1'b1, 5'd1, 32'd3, 1'b1, 5'd2,  32'd2,  1'b0, 5'd0);
        tick();
        chk("pre_rst_busy", busy, 32'h0000_0600);
        chk("pre_rst_rfwr", {31'd0, RFWr}, 32'd1);
        rst = 1'b1;
        idle();
        #1;
        chk("mid_rst_rfwr",  {31'd0, RFWr}, 32'd0);
        chk("mid_rst_a3",    {27'd0, A3}, 32'd0);
        chk("mid_rst_wd",    WD, 32'd0);
        chk("mid_rst_busy",  busy, 32'd0);
        chk("mid_rst_ready", {31'd0, lng_ready}, 32'd1);
        chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_rfwr", k),  {31'd0, RFWr}, 32'd0);
            chk($sformatf("post_rst%0d_ready", k), {31'd0, lng_ready}, 32'd1);
            chk($sformatf("post_rst%0d_busy", k),  busy, 32'd0);
        end
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        tick();
        chk("post_rst_pipe_rfwr", {31'd0, RFWr}, 32'd1);
        chk("post_rst_pipe_a3",   {27'd0, A3}, 32'd6);
        chk("post_rst_pipe_wd",   WD, 32'h66);
        idle();
        tick();
        chk("post_rst_idle_rfwr", {31'd0, RFWr}, 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of long-latency write-back FIFO entries (power of two, at least 2).
REQ-002 Parameter STARVE_MAX, default 8, SHALL set the consecutive-cycle limit before a starved FIFO head forces a pipeline stall.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port pipe_wr, input, 1: the main pipeline write-back is valid this cycle.
REQ-006 Port pipe_a, input, 5: main pipeline destination register.
REQ-007 Port pipe_wd, input, 32: main pipeline write data.
REQ-008 Port lng_valid, input, 1: the long-latency unit (load miss/mul/div) offers a result.
REQ-009 Port lng_ready, output, 1: a FIFO slot is free.
REQ-010 Port lng_a, input, 5: long result destination register.
REQ-011 Port lng_wd, input, 32: long result data.
REQ-012 Port iss_valid, input, 1: a long-latency operation is issued this cycle.
REQ-013 Port iss_a, input, 5: destination register of the issued long operation.
REQ-014 Port A3, output, 5: register file write address.
REQ-015 Port WD, output, 32: register file write data.
REQ-016 Port RFWr, output, 1: register file write enable.
REQ-017 Port busy, output, 32: scoreboard; bit n set means register n awaits a long result.
REQ-018 Port stall_req, output, 1: asks the hazard unit to bubble the pipeline.

Function
REQ-019 A handshake SHALL transfer on lng_valid && lng_ready; lng_ready SHALL equal (count < DEPTH), independent of same-cycle dequeue.
REQ-020 Each cycle, pipe_wr=1 SHALL win the write port; otherwise a non-empty FIFO SHALL pop its head.
REQ-021 A3, WD and RFWr SHALL be registered: the winner selected in cycle N SHALL appear on A3/WD/RFWr in cycle N+1 (latency 1).
REQ-022 A winner with destination 0 SHALL still be consumed (FIFO pop), but RFWr SHALL be 0 for it.
REQ-023 With no winner, RFWr SHALL be 0; A3/WD SHALL hold their previous values.
REQ-024 A FIFO enqueue and pop in the same cycle SHALL leave count unchanged and keep order intact.
REQ-025 A FIFO SHALL enqueue and pop in strict FIFO order with wrap-around pointers.
REQ-026 iss_valid with iss_a != 0 SHALL set busy[iss_a] on the next edge; iss_a=0 SHALL be ignored.
REQ-027 A FIFO pop with destination n != 0 SHALL clear busy[n] on the same edge that registers the write.
REQ-028 A simultaneous set and clear of the same busy bit SHALL leave it set.
REQ-029 A 3-bit-or-wider starve counter SHALL increment when the FIFO is non-empty and pipe_wr=1; it SHALL clear on any pop or when the FIFO is empty.
REQ-030 stall_req SHALL be registered and equal (counter >= STARVE_MAX-1 with starvation continuing); it SHALL remain 1 until the next pop.
REQ-031 Pipeline writes SHALL never be dropped or delayed beyond latency 1, even when the FIFO is full.

Reset
REQ-032 rst=1 SHALL immediately force RFWr=0, A3=0, WD=0, busy=0, stall_req=0, count=0, pointers=0 and starve counter=0.
REQ-033 FIFO contents and in-flight long results SHALL be discarded on reset mid-operation; lng_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-034 Shared package rf_pkg SHALL hold REG_AW=5, DATA_W=32 and the FIFO entry struct {addr, data}.
REQ-035 The FIFO SHALL be a sub-module wb_fifo (DEPTH parameter, push/pop/full/empty/count).
REQ-036 Arbitration, scoreboard and starve logic SHALL reside in rf_wb_arbiter.

Verification
REQ-037 Set pipe_wr=1, pipe_a=5, pipe_wd=0x1234 for 1 cycle -> next cycle RFWr=1, A3=5, WD=0x1234.
REQ-038 Issue iss_a=9, then lng push a=9, d=0xCAFE with pipe idle -> busy[9]=1 until the write cycle; RFWr=1, A3=9, WD=0xCAFE; busy[9]=0 after.
REQ-039 Push 4 long results with pipe_wr held 1 -> lng_ready=0 after the 4th; a 5th offer is not accepted; stall_req=1 after 8 starve cycles; dropping pipe_wr drains the entries in order.
REQ-040 Push long a=0 d=0xFFFF -> it is popped, RFWr stays 0, and count returns to 0.
REQ-041 Assert rst while the FIFO holds 3 entries and busy=0x0000_0600 -> RFWr=0, busy=0 and lng_ready=1 immediately; no stale writes after release.
REQ-042 Issue iss_a=7 in the same cycle the FIFO pops a=7 -> busy[7] remains 1.
